// File: rtl/adder_accum_ctrl_if.sv
// Bus between the accumulator controller, the switch/button panel and the adder.
// Carries panel inputs (SW, Run, ClearA_LoadB, Sub), adder operands/result and status outputs.
// slave = the controller itself, master = whatever drives the panel and supplies the adder.
interface adder_accum_ctrl_if #(
  parameter int WIDTH = 16
);
  // panel side
  logic [WIDTH-1:0] SW;
  logic             Run;
  logic             ClearA_LoadB;
  logic             Sub;
  // adder side
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  // results / status
  logic [WIDTH-1:0] Acc;
  logic [WIDTH-1:0] Breg;
  logic             Cout_flag;
  logic             Ovf_flag;
  logic             Busy;
  logic             Done;

  modport master (
    output SW, Run, ClearA_LoadB, Sub, add_s, add_cout,
    input  add_a, add_b, add_cin, Acc, Breg, Cout_flag, Ovf_flag, Busy, Done
  );

  modport slave (
    input  SW, Run, ClearA_LoadB, Sub, add_s, add_cout,
    output add_a, add_b, add_cin, Acc, Breg, Cout_flag, Ovf_flag, Busy, Done
  );
endinterface

// File: rtl/adder_accum_ctrl.sv
// Accumulator front-end for an external combinational adder: A <= A +/- B on each Run press.
// Latency: ADD_LAT cycles from the Run rising edge to Acc/Done update.
// No backpressure: Run edges, ClearA_LoadB and SW are ignored while Busy.
//
// Ports: Clk, Reset (async, active low) plain; everything else on bus (slave modport):
//   SW/Run/ClearA_LoadB/Sub panel inputs, add_a/add_b/add_cin operands to the adder,
//   add_s/add_cout adder result, Acc/Breg/Cout_flag/Ovf_flag/Busy/Done status.
module adder_accum_ctrl #(
  parameter int ADD_LAT = 2,   // settle cycles, 1..15
  parameter int WIDTH   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  adder_accum_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ADD_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic             run_q;
  logic             start;
  logic             capture;
  logic             do_load;
  logic             do_launch;
  logic             busy_c;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             cout_flag;
  logic             ovf_flag;
  logic             done;

  // run_q resets high so a Run held through reset release is not seen as an edge.
  assign start   = bus.Run & ~run_q;
  assign capture = (state == SETTLE) && (cnt == 4'd0);

  // ---------------- state register ----------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.ClearA_LoadB && start) state_nxt = SETTLE;
      SETTLE:  if (cnt == 4'd0)                state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- output / action decode ----------------
  // Clear/load wins over a coincident start; that start is simply lost.
  always_comb begin
    busy_c    = 1'b0;
    do_load   = 1'b0;
    do_launch = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ClearA_LoadB) do_load   = 1'b1;
        else if (start)       do_launch = 1'b1;
      end
      SETTLE:  busy_c = 1'b1;
      default: busy_c = 1'b0;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_q     <= 1'b1;
      cnt       <= 4'd0;
      acc       <= '0;
      breg      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      cout_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      done      <= 1'b0;
    end else begin
      run_q <= bus.Run;
      done  <= 1'b0;

      if (do_load) begin
        acc       <= '0;
        breg      <= bus.SW;
        cout_flag <= 1'b0;
        ovf_flag  <= 1'b0;
      end

      // Subtract is A + ~B + 1; operands stay frozen for the whole settle window.
      if (do_launch) begin
        op_a   <= acc;
        op_b   <= bus.Sub ? ~breg : breg;
        op_cin <= bus.Sub;
        cnt    <= CNT_INIT;
      end

      if (state == SETTLE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      // Overflow uses the launched (possibly inverted) B, so one rule covers add and sub.
      if (capture) begin
        acc       <= bus.add_s;
        cout_flag <= bus.add_cout;
        ovf_flag  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                     (bus.add_s[WIDTH-1] != op_a[WIDTH-1]);
        done      <= 1'b1;
      end
    end
  end

  assign bus.add_a     = op_a;
  assign bus.add_b     = op_b;
  assign bus.add_cin   = op_cin;
  assign bus.Acc       = acc;
  assign bus.Breg      = breg;
  assign bus.Cout_flag = cout_flag;
  assign bus.Ovf_flag  = ovf_flag;
  assign bus.Busy      = busy_c;
  assign bus.Done      = done;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Testbench for adder_accum_ctrl: directed cases from the lab plan plus randomized
// add/subtract sequences checked against an integer-arithmetic accumulator model.
// Supplies the combinational adder itself.
module tb_adder_accum_ctrl;

  localparam int ADD_LAT = 2;
  localparam int WIDTH   = 16;

  logic clk;
  logic rst_n;

  adder_accum_ctrl_if #(.WIDTH(WIDTH)) bus ();

  adder_accum_ctrl #(.ADD_LAT(ADD_LAT), .WIDTH(WIDTH)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // The external 16-bit adder.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the accumulator should hold.
  logic [15:0] m_acc;
  logic [15:0] m_b;
  logic        m_c;
  logic        m_o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // Plain integer arithmetic: unsigned result/carry, signed range test for overflow.
  function automatic void model_op(input logic sub, output logic [15:0] r,
                                   output logic c, output logic o);
    int unsigned ua, ub;
    int          sa, sb, sr;
    ua = int'(m_acc);
    ub = int'(m_b);
    sa = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
    sb = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
    if (sub) begin
      r  = 16'((ua + 65536) - ub);
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = 16'(ua + ub);
      c  = (ua + ub) > 65535;
      sr = sa + sb;
    end
    o = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic load(input logic [15:0] sw);
    bus.SW           = sw;
    bus.ClearA_LoadB = 1'b1;
    tick();
    bus.ClearA_LoadB = 1'b0;
    m_acc = 16'h0;
    m_b   = sw;
    m_c   = 1'b0;
    m_o   = 1'b0;
    chk16("load_acc", bus.Acc, 16'h0);
    chk16("load_b", bus.Breg, sw);
    chk1("load_cout", bus.Cout_flag, 1'b0);
  endtask

  // One full Run press; Run is low on entry and on exit.
  task automatic do_op(input logic sub);
    logic [15:0] e_acc, e_b;
    logic        e_c, e_o;
    model_op(sub, e_acc, e_c, e_o);
    e_b = sub ? ~m_b : m_b;
    bus.Run = 1'b1;
    bus.Sub = sub;
    tick();
    chk1("busy_start", bus.Busy, 1'b1);
    chk1("done_start", bus.Done, 1'b0);
    chk16("add_a", bus.add_a, m_acc);
    chk16("add_b", bus.add_b, e_b);
    chk1("add_cin", bus.add_cin, sub);
    bus.Sub = ~sub;
    for (int i = 1; i < ADD_LAT; i++) begin
      tick();
      chk1("busy_hold", bus.Busy, 1'b1);
      chk1("done_early", bus.Done, 1'b0);
      chk16("acc_hold", bus.Acc, m_acc);
    end
    tick();
    chk1("done_pulse", bus.Done, 1'b1);
    chk1("busy_end", bus.Busy, 1'b0);
    chk16("acc_result", bus.Acc, e_acc);
    chk1("cout_flag", bus.Cout_flag, e_c);
    chk1("ovf_flag", bus.Ovf_flag, e_o);
    chk16("add_b_held", bus.add_b, e_b);
    m_acc = e_acc;
    m_c   = e_c;
    m_o   = e_o;
    bus.Run = 1'b0;
    tick();
    chk1("done_drop", bus.Done, 1'b0);
    chk16("acc_stable", bus.Acc, m_acc);
  endtask

  initial begin
    logic [15:0] e_acc, sw;
    logic        e_c, e_o, seen;
    int          done_cnt;

    rst_n            = 1'b0;
    bus.SW           = 16'h0;
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    bus.Sub          = 1'b0;
    m_acc = 16'h0; m_b = 16'h0; m_c = 1'b0; m_o = 1'b0;

    // Reset state
    #3;
    chk16("rst_acc", bus.Acc, 16'h0);
    chk16("rst_breg", bus.Breg, 16'h0);
    chk16("rst_add_a", bus.add_a, 16'h0);
    chk1("rst_busy", bus.Busy, 1'b0);
    chk1("rst_done", bus.Done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // 0 + 5 + 5
    load(16'h0005);
    do_op(1'b0);
    chk16("acc_5", bus.Acc, 16'h0005);
    do_op(1'b0);
    chk16("acc_a", bus.Acc, 16'h000A);

    // 0xFFFF + 0xFFFF wraps with carry, no signed overflow
    load(16'hFFFF);
    do_op(1'b0);
    do_op(1'b0);
    chk16("acc_fffe", bus.Acc, 16'hFFFE);
    chk1("cout_fffe", bus.Cout_flag, 1'b1);
    chk1("ovf_fffe", bus.Ovf_flag, 1'b0);

    // Positive overflow on add, then negative overflow on subtract
    load(16'h4000);
    do_op(1'b0);
    do_op(1'b0);
    chk16("acc_8000", bus.Acc, 16'h8000);
    chk1("ovf_add", bus.Ovf_flag, 1'b1);
    chk1("cout_add", bus.Cout_flag, 1'b0);
    do_op(1'b1);
    chk16("sub_add_b", bus.add_b, 16'hBFFF);
    chk16("acc_4000", bus.Acc, 16'h4000);
    chk1("ovf_sub", bus.Ovf_flag, 1'b1);
    chk1("cout_sub", bus.Cout_flag, 1'b1);

    // Run held 10 cycles, ClearA_LoadB pulsed mid-settle
    model_op(1'b0, e_acc, e_c, e_o);
    bus.Run = 1'b1;
    bus.Sub = 1'b0;
    tick();
    bus.ClearA_LoadB = 1'b1;
    bus.SW           = 16'h1234;
    tick();
    chk16("settle_acc", bus.Acc, m_acc);
    chk16("settle_breg", bus.Breg, m_b);
    bus.ClearA_LoadB = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.Done) done_cnt++;
    end
    chk1("held_one_done", done_cnt == 1, 1'b1);
    chk16("held_acc", bus.Acc, e_acc);
    chk16("held_breg", bus.Breg, m_b);
    m_acc = e_acc; m_c = e_c; m_o = e_o;
    bus.Run = 1'b0;
    tick();

    // Run edge coincident with ClearA_LoadB: load only
    sw = 16'hBEEF;
    bus.SW           = sw;
    bus.ClearA_LoadB = 1'b1;
    bus.Run          = 1'b1;
    tick();
    chk16("coinc_acc", bus.Acc, 16'h0);
    chk16("coinc_breg", bus.Breg, sw);
    chk1("coinc_busy", bus.Busy, 1'b0);
    m_acc = 16'h0; m_b = sw; m_c = 1'b0; m_o = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.Busy || bus.Done) seen = 1'b1;
    end
    chk1("coinc_no_op", seen, 1'b0);
    bus.Run = 1'b0;
    tick();

    // Reset one cycle into SETTLE with Run held
    do_op(1'b1);
    bus.Run = 1'b1;
    bus.Sub = 1'b0;
    tick();
    chk1("pre_rst_busy", bus.Busy, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk16("mid_rst_acc", bus.Acc, 16'h0);
    chk16("mid_rst_breg", bus.Breg, 16'h0);
    chk16("mid_rst_add_b", bus.add_b, 16'h0);
    chk1("mid_rst_busy", bus.Busy, 1'b0);
    chk1("mid_rst_done", bus.Done, 1'b0);
    chk1("mid_rst_cout", bus.Cout_flag, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    m_acc = 16'h0; m_b = 16'h0; m_c = 1'b0; m_o = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.Busy || bus.Done) seen = 1'b1;
    end
    chk1("post_rst_no_op", seen, 1'b0);
    chk16("post_rst_acc", bus.Acc, 16'h0);
    bus.Run = 1'b0;
    tick();
    do_op(1'b0);

    // Randomized accumulate sequences
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(3) == 0) load(16'($urandom));
      do_op(1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
